scan_bist_ctrl: RTL and testbench
=================================

# scan_bist_ctrl

On-chip scan BIST sequencer for the MCAC control unit scan chain. It drives the chain's test inputs (`test_mode`, `scan_enable`, `scan_in0`) from a 16-bit pseudo-random pattern generator (PRPG) and compacts the chain output `scan_out0` into a 16-bit serial-input signature register (MISR). After the programmed number of patterns it compares the signature against a golden value and reports pass/fail. It is the driving end of the CU scan interface and replaces external tester stimulus in self-test mode.

## Interface
Parameters:
- `CHAIN_LEN`, default 64: number of flops in the scan chain, ≥1.
- `NUM_PATTERNS`, default 256: number of load/capture patterns, ≥1.
- `PRPG_SEED`, default 16'hACE1: PRPG reset and start value; must be nonzero.
- `GOLDEN`, default 16'h0000: expected final signature; value comes from fault simulation.

Ports (one clock domain; reset is synchronous and active-high):
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high; returns the block to IDLE.
- `start` in 1: begin a run; sampled in IDLE and DONE only.
- `abort` in 1: cancel a run in progress; IDLE next cycle.
- `scan_out0` in 1: serial output of the scan chain.
- `test_mode` out 1: chain test mode enable; registered.
- `scan_enable` out 1: chain shift enable; registered.
- `scan_in0` out 1: serial chain input; registered.
- `busy` out 1: high in SHIFT, CAPTURE and FLUSH.
- `done` out 1: high in DONE.
- `pass` out 1: valid while `done`=1; 1 when signature == `GOLDEN`.
- `signature` out 16: current MISR contents.

## Operation
- States: IDLE, SHIFT, CAPTURE, FLUSH, DONE.
- Counters: shift counter `$clog2(CHAIN_LEN+1)` bits; pattern counter `$clog2(NUM_PATTERNS+1)` bits. No wrap is permitted before the terminal compare.
- IDLE: `start`=1 clears the MISR to 0, reloads the PRPG with `PRPG_SEED`, clears both counters, then goes to SHIFT.
- SHIFT:
  - Runs for `CHAIN_LEN` cycles with `test_mode`=1, `scan_enable`=1, `scan_in0`=prpg[15].
  - PRPG advances every SHIFT cycle: fb = p[15]^p[13]^p[12]^p[10]; p <= {p[14:0], fb}.
  - The MISR absorbs `scan_out0` only when pattern counter ≥1. The first unload is unknown chain state and is excluded.
  - MISR update: m <= {m[14:0], m[15]^m[13]^m[12]^m[10]^scan_out0}.
  - After the last shift, go to CAPTURE.
- CAPTURE:
  - One cycle with `scan_enable`=0, `test_mode`=1, `scan_in0`=0.
  - Pattern counter increments.
  - If the new count == `NUM_PATTERNS`, go to FLUSH; otherwise go to SHIFT.
- FLUSH:
  - Runs for `CHAIN_LEN` cycles with `scan_enable`=1, `test_mode`=1, `scan_in0`=0.
  - The MISR absorbs `scan_out0` every cycle. The PRPG holds.
  - Then go to DONE.
- DONE:
  - `test_mode`=0, `scan_enable`=0, `done`=1.
  - `pass` and `signature` are held.
  - `start`=1 begins a new run exactly as from IDLE.
- `abort` in SHIFT, CAPTURE or FLUSH: next state IDLE. The MISR and PRPG hold their values, and `done` stays 0.
- `start` in SHIFT, CAPTURE or FLUSH is ignored.
- `abort` and `start` together in IDLE or DONE: `abort` wins and the next state is IDLE.

## Timing
- Reset values:
  - State IDLE.
  - `test_mode`, `scan_enable`, `scan_in0`, `busy`, `done`, `pass` = 0.
  - `signature`=0; PRPG=`PRPG_SEED`.
- Reset asserted mid-run forces these values at the next edge, with no partial DONE.
- Start latency: `start` high at edge N makes `test_mode`, `scan_enable` and `busy` = 1 from edge N+1.
- `scan_out0` is sampled at the same edge that the MISR updates (zero-cycle input, no resynchronisation).
- Run length from first SHIFT cycle to first DONE cycle: NUM_PATTERNS·(CHAIN_LEN+1) + CHAIN_LEN cycles.
- `pass` is registered: it is valid in the first DONE cycle and computed from the final MISR value.

## Test plan
- Reset check: assert `reset` 2 cycles mid-SHIFT → all outputs at their reset values after the next edge. Then `start` → the first `scan_in0`=1 (bit 15 of 0xACE1).
- Stuck-0 chain: `CHAIN_LEN`=4, `NUM_PATTERNS`=2, `GOLDEN`=0, `scan_out0`=0.
  - Expect `busy` for exactly 14 cycles.
  - Expect `scan_enable` low on cycles 5 and 10 only (relative to the first busy cycle = 1).
  - Expect `done`=1, `signature`=0x0000, `pass`=1.
- Stuck-1 chain, same parameters, `scan_out0`=1:
  - The MISR absorbs 8 ones (pattern 2 shift plus flush), giving `signature`=0x00FF.
  - Expect `pass`=0.
- Loopback: `scan_out0` driven by a 4-flop behavioural shift register fed by `scan_in0` and enabled by `scan_enable`.
  - The signature must equal the reference-model value computed from the PRPG sequence.
  - The test is repeated to confirm determinism (identical signature on a second `start` from DONE).
- Abort: `abort` on cycle 7 of the run → IDLE next edge, `done`=0, `test_mode`=0. `start` + `abort` in the same cycle in IDLE → stays IDLE.
- PRPG check: over 16 SHIFT cycles from seed 0xACE1, the `scan_in0` bit sequence matches the LFSR model bit-for-bit.

Source files
------------

// File: rtl/scan_bist_if.sv
// scan_bist_if: signal bundle between the scan BIST sequencer and the scan chain / host.
//   start, abort     : run control from the host
//   scan_out0        : serial output of the scan chain
//   test_mode        : chain test mode enable
//   scan_enable      : chain shift enable
//   scan_in0         : serial input to the scan chain
//   busy, done, pass : run status
//   signature        : current MISR contents
// master : the sequencer side; slave : the chain / host side.
interface scan_bist_if;
    logic        start;
    logic        abort;
    logic        scan_out0;
    logic        test_mode;
    logic        scan_enable;
    logic        scan_in0;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] signature;

    modport master (
        input  start, abort, scan_out0,
        output test_mode, scan_enable, scan_in0, busy, done, pass, signature
    );

    modport slave (
        output start, abort, scan_out0,
        input  test_mode, scan_enable, scan_in0, busy, done, pass, signature
    );
endinterface

// File: rtl/scan_bist_ctrl.sv
// scan_bist_ctrl: scan BIST sequencer. A 16-bit PRPG feeds the scan chain, a 16-bit serial
// MISR compacts the chain output, and the final signature is compared against GOLDEN.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous active-high reset
//   bus   : scan_bist_if.master (start/abort/scan_out0 in; chain controls and status out)
module scan_bist_ctrl #(
    parameter int unsigned CHAIN_LEN    = 64,
    parameter int unsigned NUM_PATTERNS = 256,
    parameter logic [15:0] PRPG_SEED    = 16'hACE1,
    parameter logic [15:0] GOLDEN       = 16'h0000
) (
    input logic         clk,
    input logic         reset,
    scan_bist_if.master bus
);

    localparam int unsigned ShiftW = $clog2(CHAIN_LEN + 1);
    localparam int unsigned PatW   = $clog2(NUM_PATTERNS + 1);

    localparam logic [ShiftW-1:0] ShiftLast = ShiftW'(CHAIN_LEN - 1);
    localparam logic [PatW-1:0]   PatFinal  = PatW'(NUM_PATTERNS);

    typedef enum logic [2:0] {StIdle, StShift, StCapture, StFlush, StDone} state_e;

    function automatic logic [15:0] prpg_next(input logic [15:0] p);
        return {p[14:0], p[15] ^ p[13] ^ p[12] ^ p[10]};
    endfunction

    function automatic logic [15:0] misr_next(input logic [15:0] m, input logic b);
        return {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10] ^ b};
    endfunction

    state_e            state_q, state_d;
    logic [15:0]       prpg_q, prpg_d;
    logic [15:0]       misr_q, misr_d;
    logic [ShiftW-1:0] shift_cnt_q, shift_cnt_d;
    logic [PatW-1:0]   pat_cnt_q, pat_cnt_d;
    logic              test_mode_q, test_mode_d;
    logic              scan_enable_q, scan_enable_d;
    logic              scan_in0_q, scan_in0_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;

    always_comb begin
        state_d     = state_q;
        prpg_d      = prpg_q;
        misr_d      = misr_q;
        shift_cnt_d = shift_cnt_q;
        pat_cnt_d   = pat_cnt_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (bus.abort) begin
                    state_d = StIdle;
                end else if (bus.start) begin
                    state_d     = StShift;
                    misr_d      = '0;
                    prpg_d      = PRPG_SEED;
                    shift_cnt_d = '0;
                    pat_cnt_d   = '0;
                end
            end
            StShift: begin
                if (bus.abort) begin
                    state_d = StIdle;
                end else begin
                    prpg_d = prpg_next(prpg_q);
                    // First unload is unknown chain state: keep it out of the signature.
                    if (pat_cnt_q != '0) begin
                        misr_d = misr_next(misr_q, bus.scan_out0);
                    end
                    if (shift_cnt_q == ShiftLast) begin
                        shift_cnt_d = '0;
                        state_d     = StCapture;
                    end else begin
                        shift_cnt_d = shift_cnt_q + ShiftW'(1);
                    end
                end
            end
            StCapture: begin
                if (bus.abort) begin
                    state_d = StIdle;
                end else begin
                    pat_cnt_d = pat_cnt_q + PatW'(1);
                    state_d   = (pat_cnt_d == PatFinal) ? StFlush : StShift;
                end
            end
            StFlush: begin
                if (bus.abort) begin
                    state_d = StIdle;
                end else begin
                    misr_d = misr_next(misr_q, bus.scan_out0);
                    if (shift_cnt_q == ShiftLast) begin
                        shift_cnt_d = '0;
                        state_d     = StDone;
                    end else begin
                        shift_cnt_d = shift_cnt_q + ShiftW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Outputs are registered from the next state so they line up with the state register.
        busy_d        = (state_d == StShift) || (state_d == StCapture) || (state_d == StFlush);
        test_mode_d   = busy_d;
        scan_enable_d = (state_d == StShift) || (state_d == StFlush);
        // prpg_d is the value the PRPG holds during the next cycle, so its MSB is that cycle's bit.
        scan_in0_d    = (state_d == StShift) ? prpg_d[15] : 1'b0;
        done_d        = (state_d == StDone);
        pass_d        = (state_d == StDone) && (misr_d == GOLDEN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            prpg_q        <= PRPG_SEED;
            misr_q        <= '0;
            shift_cnt_q   <= '0;
            pat_cnt_q     <= '0;
            test_mode_q   <= 1'b0;
            scan_enable_q <= 1'b0;
            scan_in0_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            prpg_q        <= prpg_d;
            misr_q        <= misr_d;
            shift_cnt_q   <= shift_cnt_d;
            pat_cnt_q     <= pat_cnt_d;
            test_mode_q   <= test_mode_d;
            scan_enable_q <= scan_enable_d;
            scan_in0_q    <= scan_in0_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            pass_q        <= pass_d;
        end
    end

    assign bus.test_mode   = test_mode_q;
    assign bus.scan_enable = scan_enable_q;
    assign bus.scan_in0    = scan_in0_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.pass        = pass_q;
    assign bus.signature   = misr_q;

endmodule

// File: tb/tb_scan_bist_ctrl.sv
// tb_scan_bist_ctrl: directed bench for scan_bist_ctrl with a signature/scan_in0 scoreboard.
module tb_scan_bist_ctrl;

    localparam int unsigned CL   = 4;
    localparam int unsigned NP   = 2;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam int unsigned RUN_LEN = NP * (CL + 1) + CL;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    scan_bist_if bif ();
    scan_bist_if pif ();

    scan_bist_ctrl #(
        .CHAIN_LEN   (CL),
        .NUM_PATTERNS(NP),
        .PRPG_SEED   (SEED),
        .GOLDEN      (16'h0000)
    ) u_dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bif)
    );

    // Longer chain instance used only to watch 16 uninterrupted SHIFT cycles.
    scan_bist_ctrl #(
        .CHAIN_LEN   (16),
        .NUM_PATTERNS(1),
        .PRPG_SEED   (SEED),
        .GOLDEN      (16'h0000)
    ) u_prpg (
        .clk  (clk),
        .reset(reset),
        .bus  (pif)
    );

    // Chain stand-in: 0 = stuck-0, 1 = stuck-1, 2 = 4-flop loopback.
    int            chain_mode;
    logic [CL-1:0] chain;

    always @(posedge clk) begin
        if (reset) chain <= '0;
        else if (bif.scan_enable) chain <= {chain[CL-2:0], bif.scan_in0};
    end

    assign bif.scan_out0 = (chain_mode == 0) ? 1'b0 : (chain_mode == 1) ? 1'b1 : chain[CL-1];
    assign pif.scan_out0 = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    logic        si_q[$];
    logic [15:0] sig_q[$];
    logic        pass_q[$];

    function automatic logic [15:0] lfsr_step(input logic [15:0] p);
        return {p[14:0], p[15] ^ p[13] ^ p[12] ^ p[10]};
    endfunction

    function automatic logic [15:0] misr_step(input logic [15:0] m, input logic b);
        return {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10] ^ b};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_test_mode"}, bif.test_mode, 0);
        check({tag, "_scan_enable"}, bif.scan_enable, 0);
        check({tag, "_scan_in0"}, bif.scan_in0, 0);
        check({tag, "_busy"}, bif.busy, 0);
        check({tag, "_done"}, bif.done, 0);
        check({tag, "_pass"}, bif.pass, 0);
        check({tag, "_signature"}, bif.signature, 16'h0000);
    endtask

    // Reference run: PRPG bits for every SHIFT cycle and the final signature.
    task automatic push_run(input int mode, input bit use_const, input logic [15:0] sig_const);
        logic [15:0]   p;
        logic [15:0]   m;
        logic [CL-1:0] ch;
        logic          so;
        p  = SEED;
        m  = '0;
        ch = '0;
        si_q.delete();
        for (int pat = 0; pat < int'(NP); pat++) begin
            for (int s = 0; s < int'(CL); s++) begin
                so = (mode == 0) ? 1'b0 : (mode == 1) ? 1'b1 : ch[CL-1];
                si_q.push_back(p[15]);
                if (pat >= 1) m = misr_step(m, so);
                ch = {ch[CL-2:0], p[15]};
                p  = lfsr_step(p);
            end
        end
        for (int s = 0; s < int'(CL); s++) begin
            so = (mode == 0) ? 1'b0 : (mode == 1) ? 1'b1 : ch[CL-1];
            m  = misr_step(m, so);
            ch = {ch[CL-2:0], 1'b0};
        end
        if (use_const) m = sig_const;
        sig_q.push_back(m);
        pass_q.push_back(m == 16'h0000);
    endtask

    task automatic do_run(input string tag, input int mode, input bit use_const,
                          input logic [15:0] sig_const);
        int          cyc;
        int          busy_cnt;
        int          pos;
        logic        exp_si;
        logic [15:0] exp_sig;
        logic        exp_pass;
        chain_mode = mode;
        push_run(mode, use_const, sig_const);
        bif.start = 1'b1;
        tick();
        bif.start = 1'b0;
        cyc      = 0;
        busy_cnt = 0;
        while (!bif.done && cyc < 200) begin
            cyc++;
            if (bif.busy) busy_cnt++;
            check({tag, "_test_mode"}, bif.test_mode, 1);
            if (cyc <= int'(NP * (CL + 1))) begin
                pos = (cyc - 1) % int'(CL + 1);
                if (pos < int'(CL)) begin
                    exp_si = (si_q.size() > 0) ? si_q.pop_front() : 1'bx;
                    check({tag, "_scan_in0"}, bif.scan_in0, exp_si);
                    check({tag, "_se_shift"}, bif.scan_enable, 1);
                end else begin
                    check({tag, "_se_capture"}, bif.scan_enable, 0);
                end
            end else begin
                check({tag, "_se_flush"}, bif.scan_enable, 1);
                check({tag, "_si_flush"}, bif.scan_in0, 0);
            end
            tick();
        end
        exp_sig  = sig_q.pop_front();
        exp_pass = pass_q.pop_front();
        check({tag, "_run_len"}, 16'(cyc), 16'(RUN_LEN));
        check({tag, "_busy_cycles"}, 16'(busy_cnt), 16'(RUN_LEN));
        check({tag, "_done"}, bif.done, 1);
        check({tag, "_busy_in_done"}, bif.busy, 0);
        check({tag, "_tm_in_done"}, bif.test_mode, 0);
        check({tag, "_signature"}, bif.signature, exp_sig);
        check({tag, "_pass"}, bif.pass, exp_pass);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] p;
        bif.start  = 1'b0;
        bif.abort  = 1'b0;
        pif.start  = 1'b0;
        pif.abort  = 1'b0;
        chain_mode = 0;
        reset      = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check_reset_vals("reset");

        // Start latency, then reset for 2 cycles mid-SHIFT.
        bif.start = 1'b1;
        tick();
        bif.start = 1'b0;
        check("lat_busy", bif.busy, 1);
        check("lat_test_mode", bif.test_mode, 1);
        check("lat_scan_enable", bif.scan_enable, 1);
        check("lat_scan_in0", bif.scan_in0, 1);
        tick();
        reset = 1'b1;
        tick();
        check_reset_vals("midrun_reset");
        tick();
        reset = 1'b0;
        check_reset_vals("midrun_reset2");

        do_run("stuck0", 0, 1'b1, 16'h0000);
        do_run("stuck1", 1, 1'b1, 16'h00FF);
        do_run("loop1", 2, 1'b0, 16'h0000);
        do_run("loop2", 2, 1'b0, 16'h0000);

        // Abort on cycle 7 of a run.
        chain_mode = 0;
        bif.start = 1'b1;
        tick();
        bif.start = 1'b0;
        for (int i = 1; i < 7; i++) tick();
        check("abort_busy_before", bif.busy, 1);
        bif.abort = 1'b1;
        tick();
        bif.abort = 1'b0;
        check("abort_busy", bif.busy, 0);
        check("abort_done", bif.done, 0);
        check("abort_test_mode", bif.test_mode, 0);
        check("abort_scan_enable", bif.scan_enable, 0);
        bif.start = 1'b1;
        bif.abort = 1'b1;
        tick();
        bif.start = 1'b0;
        bif.abort = 1'b0;
        check("start_abort_busy", bif.busy, 0);
        check("start_abort_test_mode", bif.test_mode, 0);
        check("start_abort_done", bif.done, 0);
        tick();
        check("start_abort_stays_idle", bif.busy, 0);

        // 16 consecutive SHIFT cycles on the long-chain instance.
        si_q.delete();
        p = SEED;
        for (int i = 0; i < 16; i++) begin
            si_q.push_back(p[15]);
            p = lfsr_step(p);
        end
        pif.start = 1'b1;
        tick();
        pif.start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("prpg_bit%0d", i), pif.scan_in0, si_q.pop_front());
            check($sformatf("prpg_se%0d", i), pif.scan_enable, 1);
            tick();
        end
        check("prpg_capture_se", pif.scan_enable, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
